lcd_ctrl: RTL
=============

Name: lcd_ctrl

Overview:
Sequencer for the LCD character datapath: drives its select lines (init_sel, data_sel, DB_sel, field/state, index) and the HD44780 bus strobes (E, RS, RW). After power-up it runs the 4-command init sequence, then repaints one 8-character frame (4 operand digits, then 4 operation-name characters) on each update request or refresh-timer expiry. It also generates the cursor-blink square wave consumed by the datapath. The block sits between the calculator top-level FSM (which owns statelocal/inputIndex) and the datapath feeding the LCD pins.

Parameters:
T_POWER, 750000, cycles of power-on wait before first command (15 ms at 50 MHz)
T_AS, 2, cycles RS/data stable before E rises
T_PW, 12, cycles E held high
T_H, 2, cycles data/RS held after E falls
T_CMD, 2000, execution wait after a normal command or character write (40 us)
T_CLR, 82000, execution wait after the clear command (1.64 ms)
T_REFRESH, 2500000, cycles between automatic frame repaints (50 ms)
T_BLINK, 12500000, half-period of blink (250 ms)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
update  in  1  single-cycle request to repaint the frame
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  0 = command, 1 = character data
lcd_rw  out  1  tied 0 (write only)
init_sel  out  2  datapath command select (0 clear, 1 displayOn, 2 entryMode, 3 functionSet)
data_sel  out  1  0 = command path, 1 = character path
db_sel  out  1  0 = fixed 0xCC, 1 = datapath output
field  out  2  datapath state: 0 digits, 1 operation text, 2 blank
index  out  2  character index within field
blink  out  1  cursor-blink square wave
busy  out  1  high while any write or wait is in progress
init_done  out  1  high once the init sequence is complete; sticky until reset

Behaviour:
- Reset values (asynchronous, rst_n low): lcd_e=0, lcd_rs=0, lcd_rw=0, init_sel=3, data_sel=0, db_sel=0, field=2, index=0, blink=0, busy=1, init_done=0. The update-pending flag, the refresh timer and the blink timer are cleared.
- Reset mid-write forces lcd_e low immediately. The full power-on sequence restarts after reset release.
- Top FSM states: PWR_WAIT, INIT, IDLE, FRAME.
  - PWR_WAIT: count T_POWER cycles, then go to INIT.
  - INIT: write init_sel 3, 2, 1, 0 in that order with rs=0, data_sel=0, db_sel=1. The final write (clear) uses T_CLR; the others use T_CMD. After the clear, set init_done=1 and go to IDLE.
  - IDLE: busy=0, field=2, lcd_e=0. Go to FRAME when the pending flag is set or the refresh timer reaches T_REFRESH-1. Clear the pending flag and the refresh timer on entry to FRAME.
  - FRAME, 9 writes in order:
    1. Clear (init_sel 0, data_sel 0, rs 0, wait T_CLR).
    2. Four digit writes: field 0, index 3, 2, 1, 0.
    3. Four text writes: field 1, index 0, 1, 2, 3.
    All character writes use data_sel 1, db_sel 1, rs 1 and wait T_CMD. Return to IDLE after the ninth write.
- Write engine sub-states: SETUP (T_AS cycles, e=0), PULSE (T_PW cycles, e=1), HOLD (T_H cycles, e=0), EXEC (T_CMD or T_CLR cycles).
  - lcd_rs, init_sel, data_sel, db_sel, field and index are registered and change only on entry to SETUP.
  - They stay constant through HOLD.
- Total cycles per write = T_AS + T_PW + T_H + wait. Counters are sized with $clog2 of the largest parameter.
- update asserted in any state other than IDLE sets the pending flag. Multiple requests collapse into one. update in IDLE starts FRAME on the next cycle. update before init_done is held pending.
- The refresh timer runs only in IDLE. It saturates at T_REFRESH-1.
- busy = 1 in every state except IDLE.

Optional Feature:
LCD_BLINK_EN: when defined, blink toggles every T_BLINK cycles from a free-running counter that is independent of the FSM. Each blink edge also sets the pending flag, so the cursor digit visibly flashes. When not defined, blink is constant 0, the blink counter is absent, and repaints come only from update or the refresh timer.

Decomposition:
- Shared package lcd_pkg holds:
  - the FSM state enums (top and write-engine);
  - init_sel codes CMD_CLEAR=0, CMD_DISPLAY_ON=1, CMD_ENTRY_MODE=2, CMD_FUNCTION_SET=3;
  - field codes FIELD_DIGITS=0, FIELD_OP=1, FIELD_BLANK=2.
- One sub-module, lcd_write_timer: the SETUP/PULSE/HOLD/EXEC engine with a start/done handshake, the wait length as an input and lcd_e as an output.

Test Plan:
- All parameters = 4, T_CLR = 10. Release rst_n → exactly 4 E pulses with init_sel 3, 2, 1, 0 and rs=0. init_done rises 10 cycles after the 4th E falls plus T_H; busy then falls.
- Pulse update in IDLE → 9 E pulses. Pulse 1: rs=0, init_sel=0. Pulses 2–5: rs=1, field=0, index 3, 2, 1, 0. Pulses 6–9: field=1, index 0, 1, 2, 3. Then busy=0.
- Pulse update three times during a frame → exactly one extra frame follows, with no IDLE gap beyond one cycle.
- No update, T_REFRESH=20 → a frame starts 20 cycles after IDLE entry, repeating.
- Assert rst_n low while lcd_e=1 in a frame → lcd_e=0 in the same cycle. On release, all outputs are at reset values and PWR_WAIT restarts.
- LCD_BLINK_EN defined, T_BLINK=8 → blink toggles every 8 cycles and each toggle triggers a frame. Undefined → blink stays 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and codes for the LCD character-datapath sequencer.
// Holds the top and write-engine state enums, init_sel/field codes, the
// per-write select record and helpers that build it for each write step.
package lcd_pkg;

  typedef enum logic [1:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    FRAME
  } top_state_e;

  typedef enum logic [2:0] {
    WR_IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } wr_state_e;

  // Datapath command select codes
  localparam logic [1:0] CMD_CLEAR        = 2'd0;
  localparam logic [1:0] CMD_DISPLAY_ON   = 2'd1;
  localparam logic [1:0] CMD_ENTRY_MODE   = 2'd2;
  localparam logic [1:0] CMD_FUNCTION_SET = 2'd3;

  // Datapath field codes
  localparam logic [1:0] FIELD_DIGITS = 2'd0;
  localparam logic [1:0] FIELD_OP     = 2'd1;
  localparam logic [1:0] FIELD_BLANK  = 2'd2;

  localparam logic [3:0] INIT_LAST  = 4'd3;  // four init commands, steps 0..3
  localparam logic [3:0] FRAME_LAST = 4'd8;  // clear + 8 characters, steps 0..8

  // Everything the datapath and bus need for one write, plus which wait follows
  typedef struct packed {
    logic       rs;
    logic [1:0] init_sel;
    logic       data_sel;
    logic       db_sel;
    logic [1:0] field;
    logic [1:0] index;
    logic       use_clr;
  } wr_sel_t;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Init sequence: functionSet, entryMode, displayOn, clear
  function automatic wr_sel_t init_write(input logic [1:0] step);
    wr_sel_t s;
    s.rs       = 1'b0;
    s.init_sel = 2'(CMD_FUNCTION_SET - step);
    s.data_sel = 1'b0;
    s.db_sel   = 1'b1;
    s.field    = FIELD_BLANK;
    s.index    = 2'd0;
    s.use_clr  = (step == 2'd3);
    return s;
  endfunction

  // Frame: clear, digits right-to-left (index 3..0), op text left-to-right (0..3)
  function automatic wr_sel_t frame_write(input logic [3:0] step);
    wr_sel_t s;
    s.init_sel = CMD_CLEAR;
    s.db_sel   = 1'b1;
    if (step == 4'd0) begin
      s.rs       = 1'b0;
      s.data_sel = 1'b0;
      s.field    = FIELD_BLANK;
      s.index    = 2'd0;
      s.use_clr  = 1'b1;
    end else if (step <= 4'd4) begin
      s.rs       = 1'b1;
      s.data_sel = 1'b1;
      s.field    = FIELD_DIGITS;
      s.index    = 2'(3'd4 - step[2:0]);
      s.use_clr  = 1'b0;
    end else begin
      s.rs       = 1'b1;
      s.data_sel = 1'b1;
      s.field    = FIELD_OP;
      s.index    = 2'(step - 4'd5);
      s.use_clr  = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/lcd_write_timer.sv
// HD44780 write-cycle engine: SETUP (e low), PULSE (e high), HOLD (e low),
// then EXEC for the caller-supplied wait. done is high in the last EXEC
// cycle; a start in that same cycle chains the next write with no gap.
module lcd_write_timer
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS = 2,
  parameter int unsigned T_PW = 12,
  parameter int unsigned T_H  = 2,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] wait_cycles,
  output logic          lcd_e,
  output logic          done
);

  wr_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          e_q, e_d;

  assign done  = (state_q == EXEC) && (cnt_q == wait_q - CW'(1));
  assign lcd_e = e_q;

  // Phase sequencing and per-phase cycle counting
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    wait_d  = wait_q;
    unique case (state_q)
      WR_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = SETUP;
          wait_d  = wait_cycles;
        end
      end
      SETUP: if (cnt_q == CW'(T_AS - 1)) begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: if (cnt_q == CW'(T_PW - 1)) begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: if (cnt_q == CW'(T_H - 1)) begin
        state_d = EXEC;
        cnt_d   = '0;
      end
      EXEC: if (done) begin
        cnt_d = '0;
        if (start) begin
          state_d = SETUP;
          wait_d  = wait_cycles;
        end else begin
          state_d = WR_IDLE;
        end
      end
      default: begin
        state_d = WR_IDLE;
        cnt_d   = '0;
      end
    endcase
    // E is registered so the strobe is glitch-free at the pin
    e_d = (state_d == PULSE);
  end

  // Engine registers; async reset drops E immediately even mid-pulse
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q <= WR_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      e_q     <= e_d;
    end
  end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD character-datapath sequencer: power-on wait, 4-command init, then one
// 8-character frame repaint per update request or refresh-timer expiry.
// Optional feature macro: LCD_BLINK_EN (cursor-blink square wave that also
// requests a repaint on every edge). Undefined: blink is held at 0.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWER   = 750000,
  parameter int unsigned T_AS      = 2,
  parameter int unsigned T_PW      = 12,
  parameter int unsigned T_H       = 2,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLR     = 82000,
  parameter int unsigned T_REFRESH = 2500000,
  parameter int unsigned T_BLINK   = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [1:0] init_sel,
  output logic       data_sel,
  output logic       db_sel,
  output logic [1:0] field,
  output logic [1:0] index,
  output logic       blink,
  output logic       busy,
  output logic       init_done
);

  localparam int unsigned T_MAX = max_of(
    max_of(max_of(T_POWER, T_AS), max_of(T_PW, T_H)),
    max_of(max_of(T_CMD, T_CLR), max_of(T_REFRESH, T_BLINK)));
  localparam int unsigned CW = $clog2(T_MAX + 1);

  localparam wr_sel_t SEL_RESET = '{
    rs: 1'b0, init_sel: CMD_FUNCTION_SET, data_sel: 1'b0, db_sel: 1'b0,
    field: FIELD_BLANK, index: 2'd0, use_clr: 1'b0};

  top_state_e    state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [CW-1:0] pwr_q, pwr_d;
  logic [CW-1:0] refresh_q, refresh_d;
  logic          pending_q, pending_d;
  logic          init_done_q, init_done_d;
  logic          busy_q, busy_d;
  wr_sel_t       sel_q, sel_d;

  logic          wr_start;
  logic [CW-1:0] wr_wait;
  logic          wr_done;
  logic          blink_evt;
  logic          repaint;

  lcd_write_timer #(
    .T_AS (T_AS),
    .T_PW (T_PW),
    .T_H  (T_H),
    .CW   (CW)
  ) u_write_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (wr_start),
    .wait_cycles (wr_wait),
    .lcd_e       (lcd_e),
    .done        (wr_done)
  );

`ifdef LCD_BLINK_EN
  logic [CW-1:0] blink_cnt_q;
  logic          blink_q;

  assign blink_evt = (blink_cnt_q == CW'(T_BLINK - 1));
  assign blink     = blink_q;

  // Free-running half-period counter, independent of the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_evt) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CW'(1);
    end
  end
`else
  assign blink_evt = 1'b0;
  assign blink     = 1'b0;
`endif

  // In IDLE a request acts immediately; elsewhere it is remembered
  assign repaint = pending_q || update || (refresh_q == CW'(T_REFRESH - 1));

  // Top sequencer: picks the next write and hands it to the engine
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pwr_d       = pwr_q;
    refresh_d   = refresh_q;
    init_done_d = init_done_q;
    sel_d       = sel_q;
    wr_start    = 1'b0;
    // Requests collapse: any number of them leave one pending repaint
    pending_d   = pending_q || (update && (state_q != IDLE)) || blink_evt;
    unique case (state_q)
      PWR_WAIT: begin
        if (pwr_q == CW'(T_POWER - 1)) begin
          state_d  = INIT;
          step_d   = 4'd0;
          wr_start = 1'b1;
          sel_d    = init_write(2'd0);
        end else begin
          pwr_d = pwr_q + CW'(1);
        end
      end
      INIT: begin
        if (wr_done) begin
          if (step_q == INIT_LAST) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
            sel_d.field = FIELD_BLANK;
          end else begin
            step_d   = step_q + 4'd1;
            wr_start = 1'b1;
            sel_d    = init_write(step_q[1:0] + 2'd1);
          end
        end
      end
      IDLE: begin
        if (repaint) begin
          state_d   = FRAME;
          step_d    = 4'd0;
          wr_start  = 1'b1;
          sel_d     = frame_write(4'd0);
          pending_d = 1'b0;
          refresh_d = '0;
        end else if (refresh_q != CW'(T_REFRESH - 1)) begin
          refresh_d = refresh_q + CW'(1);
        end
      end
      FRAME: begin
        if (wr_done) begin
          if (step_q == FRAME_LAST) begin
            state_d     = IDLE;
            sel_d.field = FIELD_BLANK;
          end else begin
            step_d   = step_q + 4'd1;
            wr_start = 1'b1;
            sel_d    = frame_write(step_q + 4'd1);
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase
    wr_wait = sel_d.use_clr ? CW'(T_CLR) : CW'(T_CMD);
    busy_d  = (state_d != IDLE);
  end

  // Sequencer registers; selects load together with the engine entering SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      step_q      <= 4'd0;
      pwr_q       <= '0;
      refresh_q   <= '0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      sel_q       <= SEL_RESET;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pwr_q       <= pwr_d;
      refresh_q   <= refresh_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
    end
  end

  assign lcd_rs    = sel_q.rs;
  assign lcd_rw    = 1'b0;
  assign init_sel  = sel_q.init_sel;
  assign data_sel  = sel_q.data_sel;
  assign db_sel    = sel_q.db_sel;
  assign field     = sel_q.field;
  assign index     = sel_q.index;
  assign busy      = busy_q;
  assign init_done = init_done_q;

endmodule
